fixed_point_seq_multiplier: RTL and testbench

- Sequential sign-magnitude fixed-point multiplier; sits directly downstream of the fixed-point subtractor and consumes its N-bit difference word (bit N-1 = sign, bits N-2:0 = magnitude, Q fractional bits).
- Shift-add datapath processes one multiplier bit per clock, trading latency for area.
- Valid/ready handshake on both sides, so it drops into the arithmetic pipeline between combinational stages.

---
 rtl/fixed_point_seq_multiplier.sv | 133 +++++++++++++
 tb/tb_fixed_point_seq_multiplier.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_seq_multiplier.sv
// Sequential sign-magnitude fixed-point multiplier.
// Shift-add datapath: one multiplier bit per clock, N-1 cycles per product,
// valid/ready handshake on both the operand and the result side.
module fixed_point_seq_multiplier #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] c,
  output logic         ovf
);

  localparam int unsigned MW = N - 1;                  // magnitude width
  localparam int unsigned AW = 2 * MW;                 // full-precision product width
  localparam int unsigned CW = (MW > 1) ? $clog2(MW) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic [MW-1:0]   r_mag_a;
  logic [MW-1:0]   r_mag_b;
  logic            r_sgn;
  logic [AW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_c;
  logic            r_ovf;

  logic            w_last;
  logic [AW-1:0]   w_addend;
  logic [AW-1:0]   w_acc_sum;
  logic [AW-1:0]   w_p;
  logic            w_sat;
  logic [MW-1:0]   w_mag;
  logic            w_sign;

  // Shift-add step and result formation from the post-add accumulator.
  always_comb begin
    w_last    = (r_cnt == CW'(N - 2));
    w_addend  = r_mag_b[r_cnt] ? (AW'(r_mag_a) << r_cnt) : '0;
    w_acc_sum = r_acc + w_addend;
    w_p       = w_acc_sum >> Q;                 // truncate toward zero, no rounding
    w_sat     = |w_p[AW-1:MW];
    w_mag     = w_sat ? {MW{1'b1}} : w_p[MW-1:0];
    w_sign    = r_sgn & (|w_mag);               // never emit negative zero
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // FSM next-state and handshake outputs.
  always_comb begin
    w_state_d = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Gated by rst so in_ready is low for the whole reset interval.
        in_ready = ~rst;
        if (in_valid) begin
          w_state_d = StBusy;
        end
      end
      StBusy: begin
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Operand capture, accumulation and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_sgn   <= 1'b0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_c     <= '0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_mag_a <= a[N-2:0];
            r_mag_b <= b[N-2:0];
            r_sgn   <= a[N-1] ^ b[N-1];
            r_acc   <= '0;
            r_cnt   <= '0;
          end
        end
        StBusy: begin
          r_acc <= w_acc_sum;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_c   <= {w_sign, w_mag};
            r_ovf <= w_sat;
          end
        end
        default: ;
      endcase
    end
  end

  assign c   = r_c;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_fixed_point_seq_multiplier.sv
// Self-checking bench for fixed_point_seq_multiplier: directed vector table,
// backpressure / reset-abort / throughput sequences, and random operands
// checked against an arithmetic reference model.
module tb_fixed_point_seq_multiplier;

  localparam int unsigned Q = 15;
  localparam int unsigned N = 32;
  localparam int Lat = N - 1;
  localparam int Bound = 200;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] c;
  logic         ovf;

  int n_cmp;
  int n_fail;
  int cyc;

  fixed_point_seq_multiplier #(
    .Q(Q),
    .N(N)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [N-1:0] va;
    logic [N-1:0] vb;
    logic [N-1:0] exp_c;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: exact product of magnitudes, scaled by 2^-Q, saturated to N-1 bits.
  function automatic void model(input logic [N-1:0] ma, input logic [N-1:0] mb,
                                output logic [N-1:0] mc, output logic movf);
    bit [63:0] pa;
    bit [63:0] pb;
    bit [63:0] p;
    bit [63:0] maxmag;
    bit [N-2:0] mag;
    pa = 64'(ma[N-2:0]);
    pb = 64'(mb[N-2:0]);
    p = (pa * pb) >> Q;
    maxmag = (64'd1 << (N - 1)) - 64'd1;
    if (p > maxmag) begin
      mag  = maxmag[N-2:0];
      movf = 1'b1;
    end else begin
      mag  = p[N-2:0];
      movf = 1'b0;
    end
    mc = {(ma[N-1] ^ mb[N-1]) && (mag != 0), mag};
  endfunction

  // Called #1 after a clock edge; waits (bounded) until in_ready is high.
  task automatic wait_ready(input string name);
    int k;
    k = 0;
    while (!in_ready && k < Bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!in_ready) chk({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
  endtask

  // Present one operand pair, then wait for the result; lat counts edges
  // from the acceptance edge to the edge that raises out_valid.
  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                       output logic [N-1:0] rc, output logic rovf, output int lat);
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < Bound) begin
      @(posedge clk);
      #1;
      lat++;
    end
    rc   = c;
    rovf = ovf;
  endtask

  logic [N-1:0] rc;
  logic         rovf;
  logic [N-1:0] ec;
  logic         eovf;
  int           lat;

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    cyc       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;

    vecs[0] = '{"basic",      32'h0000C000, 32'h80010000, 32'h80018000, 1'b0};
    vecs[1] = '{"sat_pos",    32'h7FFFFFFF, 32'h00010000, 32'h7FFFFFFF, 1'b1};
    vecs[2] = '{"sat_neg",    32'hFFFFFFFF, 32'h00010000, 32'hFFFFFFFF, 1'b1};
    vecs[3] = '{"neg_zero",   32'h80000000, 32'h80008000, 32'h00000000, 1'b0};
    vecs[4] = '{"underflow",  32'h00000001, 32'h80000001, 32'h00000000, 1'b0};
    vecs[5] = '{"one_by_one", 32'h00008000, 32'h00008000, 32'h00008000, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c", c, 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vector table.
    foreach (vecs[i]) begin
      wait_ready(vecs[i].name);
      do_op(vecs[i].va, vecs[i].vb, rc, rovf, lat);
      chk({vecs[i].name, "_c"}, rc, vecs[i].exp_c);
      chk({vecs[i].name, "_ovf"}, 32'(rovf), 32'(vecs[i].exp_ovf));
      chk({vecs[i].name, "_latency"}, 32'(lat), 32'(Lat));
      @(posedge clk);
      #1;
    end

    // Backpressure: result held, new operands ignored while out_ready is low.
    out_ready = 1'b0;
    wait_ready("bp");
    do_op(32'h0000C000, 32'h80010000, rc, rovf, lat);
    chk("bp_c", rc, 32'h80018000);
    for (int i = 0; i < 10; i++) begin
      a = 32'h00008000;
      b = 32'h00008000;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_out_valid_held", 32'(out_valid), 32'd1);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_c_held", c, 32'h80018000);
      chk("bp_ovf_held", 32'(ovf), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_out_valid_drop", 32'(out_valid), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    // Reset during BUSY aborts the operation.
    a = 32'h7FFFFFFF;
    b = 32'h00010000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_c", c, 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) lat++;
    end
    chk("abort_no_result", 32'(lat), 32'd0);
    wait_ready("after_abort");
    do_op(32'h00008000, 32'h00008000, rc, rovf, lat);
    chk("after_abort_c", rc, 32'h00008000);
    chk("after_abort_ovf", 32'(rovf), 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back: in_valid held high, acceptances N+1 cycles apart.
    begin
      int t[3];
      logic [N-1:0] pa[3];
      logic [N-1:0] pb[3];
      for (int k = 0; k < 3; k++) begin
        pa[k] = {1'($urandom), 11'd0, 20'($urandom)};
        pb[k] = {1'($urandom), 11'd0, 20'($urandom)};
      end
      for (int k = 0; k < 3; k++) begin
        a = pa[k];
        b = pb[k];
        in_valid = 1'b1;
        wait_ready("b2b");
        @(posedge clk);
        #1;
        t[k] = cyc;
        lat = 0;
        while (!out_valid && lat < Bound) begin
          @(posedge clk);
          #1;
          lat++;
        end
        model(pa[k], pb[k], ec, eovf);
        chk("b2b_c", c, ec);
        chk("b2b_ovf", 32'(ovf), 32'(eovf));
      end
      in_valid = 1'b0;
      chk("b2b_interval_1", 32'(t[1] - t[0]), 32'(N + 1));
      chk("b2b_interval_2", 32'(t[2] - t[1]), 32'(N + 1));
      @(posedge clk);
      #1;
    end

    // Random full-range operands, including saturation and zero cases.
    for (int k = 0; k < 20; k++) begin
      logic [N-1:0] ra;
      logic [N-1:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (k % 4 == 1) rb = rb & 32'h8001FFFF;
      if (k % 4 == 2) ra = ra & 32'h800000FF;
      if (k == 3) ra = 32'h80000000;
      wait_ready("rand");
      do_op(ra, rb, rc, rovf, lat);
      model(ra, rb, ec, eovf);
      chk("rand_c", rc, ec);
      chk("rand_ovf", 32'(rovf), 32'(eovf));
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
